// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and
// the run/stop state encoding.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CW       = 11;

    localparam int DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis with
// terminal count and next-position window decode.
module vga_axis_counter #(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int CW         = 11
) (
    input  logic          pixel_clock,
    input  logic          reset_n,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          terminal,
    output logic [CW-1:0] count_next,
    output logic          next_active,
    output logic          next_sync
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    assign terminal = (count == LAST);

    always_comb begin
        count_next = count;
        if (advance)
            count_next = terminal ? '0 : count + 1'b1;
    end

    // Decode the upcoming position so registered flags line up with count.
    assign next_active = (count_next < CW'(ACTIVE));
    assign next_sync   = (count_next >= CW'(SYNC_START)) &&
                         (count_next <  CW'(SYNC_END));

    always_ff @(posedge pixel_clock) begin
        if (!reset_n)
            count <= LAST;
        else
            count <= count_next;
    end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing with frame-aligned run/stop
// control; all outputs registered and aligned.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic          pixel_clock,
    input  logic          reset_n,
    input  logic          enable,
    output logic          h_synch,
    output logic          v_synch,
    output logic          blank,
    output logic [CW-1:0] pixel_count,
    output logic [CW-1:0] line_count,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SS    = H_ACTIVE + H_FRONT;
    localparam int V_SS    = V_ACTIVE + V_FRONT;

    state_t          state;
    state_t          state_next;
    logic            h_term;
    logic            v_term;
    logic            h_act;
    logic            v_act;
    logic            h_sy;
    logic            v_sy;
    logic            advance;
    logic [CW-1:0]   x_next;
    logic [CW-1:0]   y_next;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (enable) state_next = RUN;
            RUN:       if (!enable) state_next = STOP_PEND;
            STOP_PEND: begin
                if (enable)
                    state_next = RUN;
                else if (h_term && v_term)
                    state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // IDLE parks at the last pixel, so the first advance wraps to (0,0).
    assign advance = (state_next != IDLE);

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SS),
        .SYNC_END   (H_SS + H_SYNC),
        .CW         (CW)
    ) u_h (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .advance     (advance),
        .count       (pixel_count),
        .terminal    (h_term),
        .count_next  (x_next),
        .next_active (h_act),
        .next_sync   (h_sy)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SS),
        .SYNC_END   (V_SS + V_SYNC),
        .CW         (CW)
    ) u_v (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .advance     (advance && h_term),
        .count       (line_count),
        .terminal    (v_term),
        .count_next  (y_next),
        .next_active (v_act),
        .next_sync   (v_sy)
    );

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            blank       <= 1'b1;
            h_synch     <= ~H_POL;
            v_synch     <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_next;
            blank       <= !(advance && h_act && v_act);
            h_synch     <= (advance && h_sy) ? H_POL : ~H_POL;
            v_synch     <= (advance && v_sy) ? V_POL : ~V_POL;
            line_start  <= advance && (x_next == '0);
            frame_start <= advance && (x_next == '0) && (y_next == '0);
            running     <= advance;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller on a
// reduced 15x11 raster so whole frames stay short.
module tb_vga_timing_controller;

    localparam int HT = 15;
    localparam int VT = 11;

    logic        pixel_clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        h_synch;
    logic        v_synch;
    logic        blank;
    logic [10:0] pixel_count;
    logic [10:0] line_count;
    logic        line_start;
    logic        frame_start;
    logic        running;

    int errors = 0;
    int checks = 0;
    int ex = HT - 1;
    int ey = VT - 1;
    int hs_low = 0;
    int vs_low = 0;
    int ls_cnt = 0;
    int fs_cnt = 0;

    vga_timing_controller #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .H_POL    (1'b0), .V_POL (1'b0), .CW (11)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .h_synch     (h_synch),
        .v_synch     (v_synch),
        .blank       (blank),
        .pixel_count (pixel_count),
        .line_count  (line_count),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at (%0d,%0d)",
                   tag, obs, exp, ex, ey);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clock);
        @(negedge pixel_clock);
    endtask

    // Expected outputs for pixel (x,y); hsync x in 10..12, vsync y in 7..8.
    task automatic expect_px(input int x, input int y, input bit run);
        chk("pixel_count", 32'(pixel_count), x);
        chk("line_count", 32'(line_count), y);
        chk("blank", 32'(blank), 32'(!run || x >= 8 || y >= 6));
        chk("h_synch", 32'(h_synch), 32'(!(run && x >= 10 && x < 13)));
        chk("v_synch", 32'(v_synch), 32'(!(run && y >= 7 && y < 9)));
        chk("line_start", 32'(line_start), 32'(run && x == 0));
        chk("frame_start", 32'(frame_start), 32'(run && x == 0 && y == 0));
        chk("running", 32'(running), 32'(run));
    endtask

    task automatic tick_run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ex++;
            if (ex == HT) begin
                ex = 0;
                ey = (ey == VT - 1) ? 0 : ey + 1;
            end
            expect_px(ex, ey, 1'b1);
            if (h_synch === 1'b0) hs_low++;
            if (v_synch === 1'b0) vs_low++;
            if (line_start === 1'b1) ls_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
    endtask

    task automatic tick_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ex = HT - 1;
            ey = VT - 1;
            expect_px(ex, ey, 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        tick_idle(1);
        reset_n = 1'b1;
        tick_idle(3);

        enable = 1'b1;
        hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        tick_run(HT * VT);
        chk("hsync_low_cycles", hs_low, 3 * VT);
        chk("vsync_low_cycles", vs_low, 2 * HT);
        chk("line_start_count", ls_cnt, VT);
        chk("frame_start_count", fs_cnt, 1);
        tick_run(1);
        chk("frame_period_pos", 32'(pixel_count + line_count), 0);

        tick_run(33);
        enable = 1'b0;
        tick_run(131);
        chk("stop_last_x", 32'(pixel_count), HT - 1);
        tick_idle(4);

        enable = 1'b1;
        tick_run(1);
        chk("restart_fs", 32'(frame_start), 1);

        tick_run(33);
        enable = 1'b0;
        tick_run(40);
        enable = 1'b1;
        tick_run(91);
        tick_run(1);
        chk("resume_fs", 32'(frame_start), 1);

        tick_run(47);
        reset_n = 1'b0;
        tick_idle(1);
        reset_n = 1'b1;
        tick_run(1);
        chk("post_reset_fs", 32'(frame_start), 1);
        tick_run(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
